// File: rtl/mem_arb.sv
// mem_arb: arbitrates ifetch and LSB requests onto one byte-serial memory controller.
// Define MEM_ARB_STARVE_EN to let a pending ifetch win after STARVE_LIM consecutive LSB grants.
module mem_arb #(
    parameter int STARVE_LIM = 4,
    parameter int IF_BYTES   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  if_en,
    input  logic [31:0]           if_pc,
    output logic                  if_done,
    output logic [8*IF_BYTES-1:0] if_data,
    input  logic                  lsb_en,
    input  logic                  lsb_rw,
    input  logic [31:0]           lsb_addr,
    input  logic [2:0]            lsb_len,
    input  logic [31:0]           lsb_w_data,
    output logic                  lsb_done,
    output logic [31:0]           lsb_r_data,
    output logic                  mc_en,
    output logic                  mc_rw,
    output logic [31:0]           mc_addr,
    output logic [3:0]            mc_len,
    output logic [31:0]           mc_w_data,
    input  logic                  mc_done,
    input  logic [8*IF_BYTES-1:0] mc_r_data
);
    typedef enum logic [2:0] {IDLE, GAP, BUSY_IF, BUSY_LSB, DRAIN} state_t;
    state_t                r_state, w_next;
    logic                  r_if_done, r_lsb_done, r_mc_en, r_mc_rw;
    logic [8*IF_BYTES-1:0] r_if_data;
    logic [31:0]           r_lsb_r_data, r_mc_addr, r_mc_w_data;
    logic [3:0]            r_mc_len;
    logic                  w_gnt_if, w_gnt_lsb, w_done_if, w_done_lsb, w_flush, w_starve;

`ifdef MEM_ARB_STARVE_EN
    logic [3:0] r_cnt;
    assign w_starve = if_en && r_cnt == 4'(STARVE_LIM);
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (rdy) begin
            if (w_gnt_if || (r_state == IDLE && !if_en))
                r_cnt <= '0;
            else if (w_gnt_lsb && if_en)
                r_cnt <= r_cnt + 4'd1;
        end
    end
`else
    assign w_starve = STARVE_LIM < 0;
`endif

    // Stores are never flushed: once issued they must reach memory.
    always_comb begin
        w_next     = r_state;
        w_gnt_if   = 1'b0;
        w_gnt_lsb  = 1'b0;
        w_done_if  = 1'b0;
        w_done_lsb = 1'b0;
        w_flush    = rollback && (r_state == BUSY_IF || (r_state == BUSY_LSB && !r_mc_rw));
        case (r_state)
            IDLE: begin
                w_gnt_lsb = !rollback && lsb_en && !w_starve;
                w_gnt_if  = !rollback && if_en && !w_gnt_lsb;
                w_next    = w_gnt_if ? BUSY_IF : w_gnt_lsb ? BUSY_LSB : IDLE;
            end
            GAP: w_next = IDLE;
            BUSY_IF, BUSY_LSB: begin
                w_done_if  = mc_done && !w_flush && r_state == BUSY_IF;
                w_done_lsb = mc_done && !w_flush && r_state == BUSY_LSB;
                w_next     = mc_done ? GAP : w_flush ? DRAIN : r_state;
            end
            DRAIN: w_next = mc_done ? GAP : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_if_done    <= 1'b0;
            r_lsb_done   <= 1'b0;
            r_if_data    <= '0;
            r_lsb_r_data <= '0;
            r_mc_en      <= 1'b0;
            r_mc_rw      <= 1'b0;
            r_mc_addr    <= '0;
            r_mc_len     <= '0;
            r_mc_w_data  <= '0;
        end else if (rdy) begin
            r_state    <= w_next;
            r_if_done  <= w_done_if;
            r_lsb_done <= w_done_lsb;
            if (w_done_if)
                r_if_data <= mc_r_data;
            if (w_done_lsb)
                r_lsb_r_data <= mc_r_data[31:0];
            if (w_gnt_if || w_gnt_lsb) begin
                r_mc_en     <= 1'b1;
                r_mc_rw     <= w_gnt_lsb && lsb_rw;
                r_mc_addr   <= w_gnt_lsb ? lsb_addr : if_pc;
                r_mc_len    <= w_gnt_lsb ? {1'b0, lsb_len} : 4'(IF_BYTES);
                r_mc_w_data <= w_gnt_lsb ? lsb_w_data : '0;
            end else if (w_next == GAP) begin
                r_mc_en <= 1'b0;
            end
        end
    end

    // Done pulses are held in their registers while rdy is low and shown once it returns.
    assign if_done    = r_if_done && rdy;
    assign lsb_done   = r_lsb_done && rdy;
    assign if_data    = r_if_data;
    assign lsb_r_data = r_lsb_r_data;
    assign mc_en      = r_mc_en;
    assign mc_rw      = r_mc_rw;
    assign mc_addr    = r_mc_addr;
    assign mc_len     = r_mc_len;
    assign mc_w_data  = r_mc_w_data;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios followed by randomized traffic scored against a
// transaction-level model of grant order, spacing and completion.
`timescale 1ns/1ps
module tb_mem_arb;
    localparam int SL = 2;
    localparam int IB = 8;
    logic              clk = 1'b0;
    logic              rst, rdy, rollback, if_en, lsb_en, lsb_rw, mc_done;
    logic [31:0]       if_pc, lsb_addr, lsb_w_data, lsb_r_data, mc_addr, mc_w_data;
    logic [2:0]        lsb_len;
    logic [3:0]        mc_len;
    logic              if_done, lsb_done, mc_en, mc_rw;
    logic [8*IB-1:0]   if_data, mc_r_data;
    logic [2:0]        lens [3] = '{3'd1, 3'd2, 3'd4};
    logic [3:0]        ord;
    int                n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    mem_arb #(.STARVE_LIM(SL), .IF_BYTES(IB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_rw(lsb_rw), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
        .mc_en(mc_en), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_w_data(mc_w_data), .mc_done(mc_done), .mc_r_data(mc_r_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [63:0] d);
        mc_done   = 1'b1;
        mc_r_data = d;
        tick();
        mc_done   = 1'b0;
    endtask

    task automatic lsb_req(input logic rw, input logic [31:0] a, input logic [2:0] l, input logic [31:0] wd);
        lsb_en     = 1'b1;
        lsb_rw     = rw;
        lsb_addr   = a;
        lsb_len    = l;
        lsb_w_data = wd;
    endtask

    task automatic wait_en(input int lim);
        for (int k = 0; k < lim && !mc_en; k++)
            tick();
        check("grant_wait", 64'(mc_en), 64'h1);
    endtask

    task automatic random_phase(input int cycles);
        int        last_done = -10, passed = 0, lat;
        bit        busy = 0, kind_if = 0, p_if = 0, p_lsb = 0, p_mcd = 0, e_ifd, e_lsd, starve;
        logic [63:0] p_rd = '0;
        lat = int'($urandom_range(0, 3));
        for (int c = 0; c < cycles; c++) begin
            tick();
            e_ifd = 0;
            e_lsd = 0;
            if (busy && p_mcd) begin
                busy      = 0;
                last_done = c - 1;
                e_ifd     = kind_if;
                e_lsd     = !kind_if;
            end else if (!busy && c - 1 - last_done >= 2 && (p_if || p_lsb)) begin
`ifdef MEM_ARB_STARVE_EN
                starve = p_if && passed == SL;
`else
                starve = 0;
`endif
                kind_if = !p_lsb || starve;
                busy    = 1;
                check("rnd_rw", 64'(mc_rw), kind_if ? 64'h0 : 64'(lsb_rw));
                check("rnd_addr", 64'(mc_addr), kind_if ? 64'(if_pc) : 64'(lsb_addr));
                check("rnd_len", 64'(mc_len), kind_if ? 64'(IB) : 64'(lsb_len));
                if (!kind_if)
                    check("rnd_wdata", 64'(mc_w_data), 64'(lsb_w_data));
                passed = kind_if ? 0 : passed + int'(p_if);
            end
            if (!p_if)
                passed = 0;
            check("rnd_mc_en", 64'(mc_en), 64'(busy));
            check("rnd_if_done", 64'(if_done), 64'(e_ifd));
            check("rnd_lsb_done", 64'(lsb_done), 64'(e_lsd));
            if (e_ifd)
                check("rnd_if_data", if_data, p_rd);
            if (e_lsd)
                check("rnd_lsb_data", 64'(lsb_r_data), 64'(p_rd[31:0]));
            mc_done = 1'b0;
            if (mc_en) begin
                if (lat == 0) begin
                    mc_done   = 1'b1;
                    mc_r_data = {$urandom, $urandom};
                    p_rd      = mc_r_data;
                    lat       = int'($urandom_range(0, 3));
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mc_done = 1'b1;
            end
            p_mcd = mc_done;
            if (lsb_done)
                lsb_en = 1'b0;
            if (!lsb_en && $urandom_range(0, 2) == 0)
                lsb_req(1'($urandom_range(0, 1)), $urandom, lens[$urandom_range(0, 2)], $urandom);
            if (if_done)
                if_en = 1'b0;
            if (!if_en && $urandom_range(0, 3) == 0) begin
                if_en = 1'b1;
                if_pc = $urandom;
            end
            p_if  = if_en;
            p_lsb = lsb_en;
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; if_en = 1'b0; if_pc = '0;
        lsb_en = 1'b0; lsb_rw = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_w_data = '0;
        mc_done = 1'b0; mc_r_data = '0;
        tick();
        tick();
        check("rst_mc_en", 64'(mc_en), 64'h0);
        check("rst_mc_rw", 64'(mc_rw), 64'h0);
        check("rst_mc_addr", 64'(mc_addr), 64'h0);
        check("rst_mc_len", 64'(mc_len), 64'h0);
        check("rst_mc_wdata", 64'(mc_w_data), 64'h0);
        check("rst_if_done", 64'(if_done), 64'h0);
        check("rst_lsb_done", 64'(lsb_done), 64'h0);
        check("rst_if_data", if_data, 64'h0);
        check("rst_lsb_data", 64'(lsb_r_data), 64'h0);
        rst = 1'b0;
        // basic load: three mc_en cycles, one-cycle done, silent gap
        lsb_req(1'b0, 32'h100, 3'd4, 32'h0);
        tick();
        check("load_en1", 64'(mc_en), 64'h1);
        check("load_addr", 64'(mc_addr), 64'h100);
        check("load_len", 64'(mc_len), 64'h4);
        check("load_rw", 64'(mc_rw), 64'h0);
        tick();
        check("load_en2", 64'(mc_en), 64'h1);
        tick();
        check("load_en3", 64'(mc_en), 64'h1);
        serve(64'h11223344);
        check("load_drop", 64'(mc_en), 64'h0);
        check("load_done", 64'(lsb_done), 64'h1);
        check("load_data", 64'(lsb_r_data), 64'h11223344);
        check("load_no_if_done", 64'(if_done), 64'h0);
        lsb_en = 1'b0;
        if_en  = 1'b1;
        if_pc  = 32'h400;
        tick();
        check("gap_no_grant", 64'(mc_en), 64'h0);
        check("done_once", 64'(lsb_done), 64'h0);
        tick();
        check("if_grant", 64'(mc_en), 64'h1);
        check("if_addr", 64'(mc_addr), 64'h400);
        check("if_len", 64'(mc_len), 64'(IB));
        check("if_rw", 64'(mc_rw), 64'h0);
        serve(64'h8877665544332211);
        check("if_done", 64'(if_done), 64'h1);
        check("if_data", if_data, 64'h8877665544332211);
        check("if_no_lsb_done", 64'(lsb_done), 64'h0);
        if_en = 1'b0;
        tick();
        check("if_done_once", 64'(if_done), 64'h0);
        // simultaneous requests: LSB first, IF two cycles after lsb_done
        if_en = 1'b1;
        if_pc = 32'h500;
        lsb_req(1'b0, 32'h104, 3'd2, 32'h0);
        tick();
        check("both_lsb_first", 64'(mc_addr), 64'h104);
        check("both_lsb_len", 64'(mc_len), 64'h2);
        serve(64'hA5A5);
        check("both_lsb_done", 64'(lsb_done), 64'h1);
        check("both_lsb_data", 64'(lsb_r_data), 64'hA5A5);
        lsb_en = 1'b0;
        tick();
        check("both_if_wait", 64'(mc_en), 64'h0);
        tick();
        check("both_if_grant", 64'(mc_en), 64'h1);
        check("both_if_addr", 64'(mc_addr), 64'h500);
        serve(64'h0102030405060708);
        check("both_if_done", 64'(if_done), 64'h1);
        check("both_if_data", if_data, 64'h0102030405060708);
        if_en = 1'b0;
        tick();
        // rollback in IDLE swallows the request sampled with it
        lsb_req(1'b0, 32'h108, 3'd1, 32'h0);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("rb_idle_no_grant", 64'(mc_en), 64'h0);
        tick();
        check("rb_idle_grant_after", 64'(mc_en), 64'h1);
        serve(64'h5A);
        check("rb_idle_done", 64'(lsb_done), 64'h1);
        lsb_en = 1'b0;
        tick();
        // rollback during ifetch: drain without done
        if_en = 1'b1;
        if_pc = 32'h200;
        tick();
        check("drain_grant", 64'(mc_addr), 64'h200);
        rollback = 1'b1;
        if_en    = 1'b0;
        tick();
        rollback = 1'b0;
        check("drain_hold1", 64'(mc_en), 64'h1);
        tick();
        check("drain_hold2", 64'(mc_en), 64'h1);
        serve(64'hDEAD);
        check("drain_release", 64'(mc_en), 64'h0);
        check("drain_no_done", 64'(if_done), 64'h0);
        lsb_req(1'b0, 32'h300, 3'd4, 32'h0);
        tick();
        check("drain_gap", 64'(mc_en), 64'h0);
        check("drain_no_done2", 64'(if_done), 64'h0);
        tick();
        check("drain_next_grant", 64'(mc_en), 64'h1);
        check("drain_next_addr", 64'(mc_addr), 64'h300);
        serve(64'h99);
        lsb_en = 1'b0;
        tick();
        // rollback during a store is ignored
        lsb_req(1'b1, 32'h30000, 3'd1, 32'hAB);
        tick();
        check("store_rw", 64'(mc_rw), 64'h1);
        check("store_addr", 64'(mc_addr), 64'h30000);
        check("store_len", 64'(mc_len), 64'h1);
        check("store_wdata", 64'(mc_w_data), 64'hAB);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("store_hold", 64'(mc_en), 64'h1);
        serve(64'h0);
        check("store_done", 64'(lsb_done), 64'h1);
        lsb_en = 1'b0;
        tick();
        check("store_done_once", 64'(lsb_done), 64'h0);
        // rdy low right after completion defers lsb_done
        lsb_req(1'b0, 32'h120, 3'd4, 32'h0);
        tick();
        check("rdy_grant", 64'(mc_en), 64'h1);
        mc_done   = 1'b1;
        mc_r_data = 64'hCAFEF00D;
        tick();
        mc_done = 1'b0;
        rdy     = 1'b0;
        #1;
        check("rdy_hold1", 64'(lsb_done), 64'h0);
        tick();
        check("rdy_hold2", 64'(lsb_done), 64'h0);
        check("rdy_hold_en", 64'(mc_en), 64'h0);
        tick();
        check("rdy_hold3", 64'(lsb_done), 64'h0);
        tick();
        rdy = 1'b1;
        #1;
        check("rdy_resume_done", 64'(lsb_done), 64'h1);
        check("rdy_resume_data", 64'(lsb_r_data), 64'hCAFEF00D);
        lsb_en = 1'b0;
        tick();
        check("rdy_done_once", 64'(lsb_done), 64'h0);
        // grant order under continuous LSB pressure with an ifetch pending
`ifdef MEM_ARB_STARVE_EN
        ord = 4'b0100;
`else
        ord = 4'b0000;
`endif
        if_en = 1'b1;
        if_pc = 32'h800;
        lsb_req(1'b0, 32'h40, 3'd4, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_en(8);
            check("starve_order", 64'(mc_addr), ord[k] ? 64'h800 : 64'h40);
            serve(64'(k));
        end
        if_en  = 1'b0;
        lsb_en = 1'b0;
        tick();
        tick();
        check("order_quiet", 64'(mc_en), 64'h0);
        // reset mid-transaction drops it without a done pulse
        lsb_req(1'b0, 32'h180, 3'd4, 32'h0);
        tick();
        check("rst_mid_grant", 64'(mc_en), 64'h1);
        rst       = 1'b1;
        mc_done   = 1'b1;
        mc_r_data = 64'h77;
        tick();
        rst     = 1'b0;
        mc_done = 1'b0;
        lsb_en  = 1'b0;
        check("rst_mid_en", 64'(mc_en), 64'h0);
        check("rst_mid_done", 64'(lsb_done), 64'h0);
        check("rst_mid_data", 64'(lsb_r_data), 64'h0);
        tick();
        check("rst_mid_done2", 64'(lsb_done), 64'h0);
        random_phase(3000);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_LIM, default 4: consecutive LSB grants allowed while an ifetch is pending, range 1..15.
REQ-002 Parameter IF_BYTES, default 8: ifetch line length in bytes.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rdy  in  1  global enable; low freezes all state.
REQ-006 rollback  in  1  pipeline flush, one-cycle pulse.
REQ-007 if_en  in  1  ifetch request, level, held until if_done.
REQ-008 if_pc  in  32  ifetch line address.
REQ-009 if_done  out  1  one-cycle pulse: if_data valid.
REQ-010 if_data  out  8*IF_BYTES  fetched line, byte 0 in bits [7:0].
REQ-011 lsb_en  in  1  LSB request, level, held until lsb_done.
REQ-012 lsb_rw  in  1  1 = store, 0 = load.
REQ-013 lsb_addr  in  32  byte address.
REQ-014 lsb_len  in  3  byte count, 1, 2 or 4.
REQ-015 lsb_w_data  in  32  store data, little-endian.
REQ-016 lsb_done  out  1  one-cycle pulse: access complete.
REQ-017 lsb_r_data  out  32  load result, valid with lsb_done.
REQ-018 mc_en  out  1  request to the byte-serial memory controller, held until mc_done.
REQ-019 mc_rw, mc_addr[31:0], mc_len[3:0], mc_w_data[31:0]  out  request fields, stable while mc_en is high.
REQ-020 mc_done  in  1  controller completion pulse.
REQ-021 mc_r_data  in  8*IF_BYTES  controller read data; the LSB uses bits [31:0].

Function
REQ-022 States: IDLE, GAP, BUSY_IF, BUSY_LSB, DRAIN.
REQ-023 Arbitration in IDLE: lsb_en beats if_en, unless the starvation rule (REQ-032) applies.
REQ-024 Grant and mc_en:
- A grant decided in IDLE at cycle N asserts mc_en with registered fields at N+1.
- The state becomes BUSY_IF or BUSY_LSB.
REQ-025 Request fields:
- IF grant: mc_rw=0, mc_addr=if_pc, mc_len=IF_BYTES.
- LSB grant: mc_rw=lsb_rw, mc_addr=lsb_addr, mc_len={0,lsb_len}, mc_w_data=lsb_w_data.
REQ-026 On mc_done in BUSY_IF or BUSY_LSB:
- mc_en drops the next cycle.
- The matching done pulses the next cycle with the data latched from mc_r_data.
- The state moves to GAP.
REQ-027 GAP lasts exactly one cycle, with no grant, then returns to IDLE; the minimum spacing between consecutive mc_en assertions is therefore 2 cycles.
REQ-028 Rollback in BUSY_IF, or in BUSY_LSB on a load:
- The state goes to DRAIN.
- mc_en stays high until mc_done.
- No done pulse is issued.
- DRAIN then goes to GAP.
REQ-029 Rollback in BUSY_LSB on a store has no effect: the store completes and lsb_done pulses.
REQ-030 Rollback in IDLE or GAP suppresses any grant that cycle; requests sampled in the rollback cycle are ignored.
REQ-031 if_done and lsb_done are never high in the same cycle.
REQ-032 Starvation counter:
- A 4-bit counter increments on each LSB grant made while if_en is high.
- It clears on an IF grant, or when if_en is low in IDLE.
- When it equals STARVE_LIM and if_en is high, IF wins the next grant.
REQ-033 When rdy is low, state, counter and outputs hold, and done pulses are deferred until rdy returns.
REQ-034 mc_done received in IDLE or GAP is ignored.

Reset
REQ-035 With rst high at a clock edge, the following hold on the next cycle:
- State is IDLE and the counter is 0.
- mc_en, if_done and lsb_done are 0.
- mc_rw, mc_addr, mc_len and mc_w_data are 0.
- if_data and lsb_r_data are 0.
REQ-036 Reset mid-transaction abandons it silently; no done pulse is issued.
REQ-037 rst has priority over rdy and rollback.

Configuration
REQ-038 Macro MEM_ARB_STARVE_EN:
- Defined: REQ-032 is active.
- Undefined: the counter is removed and strict LSB-over-IF priority always holds; STARVE_LIM is ignored.

Verification
REQ-039 Both requesters idle; lsb_en load, addr 0x100, len 4; mc_done at the 3rd mc_en cycle with rdata 0x11223344 -> mc_en for exactly 3 cycles, lsb_done plus lsb_r_data=0x11223344 one cycle later, no mc_en in the following GAP cycle.
REQ-040 if_en and lsb_en both high in the same cycle -> the LSB is granted first; the IF is granted 2 cycles after lsb_done.
REQ-041 MEM_ARB_STARVE_EN, STARVE_LIM=2, if_en high, lsb_en continuously re-raised -> grant order LSB, LSB, IF, LSB...; without the macro, IF is never granted while lsb_en stays high.
REQ-042 Rollback pulse during an in-flight IF fetch, addr 0x200 -> mc_en held until mc_done, if_done never pulses, the next grant is 2 cycles after mc_done.
REQ-043 Rollback during a store, addr 0x30000, data 0xAB, len 1 -> the store completes and lsb_done pulses once.
REQ-044 rdy low for 3 cycles immediately after mc_done -> lsb_done is withheld and then pulses in the first cycle rdy is high again.
